// File: rtl/booth_div.sv
// Sequential signed restoring divider: 2W-bit dividend by W-bit divisor, one quotient
// bit per clock, with overflow and divide-by-zero detection.
module booth_div #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*W-1:0]   dvd,
    input  logic [W-1:0]     dvs,
    output logic [W-1:0]     quot,
    output logic [W-1:0]     rem,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic             dbz
);

    localparam int CW = $clog2(2 * W) + 1;
    localparam logic [CW-1:0]  LAST_ITER = CW'(2 * W - 1);
    localparam logic [2*W-1:0] Q_MAX_POS = (2 * W)'((64'd1 << (W - 1)) - 64'd1);
    localparam logic [2*W-1:0] Q_MAX_NEG = (2 * W)'(64'd1 << (W - 1));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic [W-1:0] neg_w(input logic [W-1:0] v);
        return ~v + {{(W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [2*W-1:0] neg_2w(input logic [2*W-1:0] v);
        return ~v + {{(2*W-1){1'b0}}, 1'b1};
    endfunction

    state_t          state_r;
    logic            sdvd_r;
    logic            sdvs_r;
    logic            dvs_zero_r;
    logic [2*W-1:0]  dvd_mag_r;
    logic [W-1:0]    dvs_mag_r;
    logic [W:0]      prem_r;
    logic [2*W-1:0]  qmag_r;
    logic [CW-1:0]   cnt_r;

    logic [2*W-1:0]  dvd_abs_s;
    logic [W-1:0]    dvs_abs_s;
    logic [W:0]      shift_s;
    logic [W+1:0]    diff_s;
    logic            q_neg_s;
    logic            q_ovf_s;
    logic [W-1:0]    quot_s;
    logic [W-1:0]    rem_s;

    // Operand magnitudes, one restoring trial step, and the sign/overflow fix-up values.
    always_comb begin
        dvd_abs_s = '0;
        dvs_abs_s = '0;
        q_ovf_s   = 1'b0;
        if (dvd[2*W-1]) begin
            dvd_abs_s = neg_2w(dvd);
        end else begin
            dvd_abs_s = dvd;
        end
        if (dvs[W-1]) begin
            dvs_abs_s = neg_w(dvs);
        end else begin
            dvs_abs_s = dvs;
        end
        // Partial remainder stays below |dvs| <= 2^(W-1), so W bits plus the new bit suffice.
        shift_s = {prem_r[W-1:0], dvd_mag_r[2*W-1]};
        diff_s  = {1'b0, shift_s} - {2'b00, dvs_mag_r};
        q_neg_s = sdvd_r ^ sdvs_r;
        if (q_neg_s) begin
            q_ovf_s = (qmag_r > Q_MAX_NEG);
            quot_s  = neg_w(qmag_r[W-1:0]);
        end else begin
            q_ovf_s = (qmag_r > Q_MAX_POS);
            quot_s  = qmag_r[W-1:0];
        end
        if (sdvd_r) begin
            rem_s = neg_w(prem_r[W-1:0]);
        end else begin
            rem_s = prem_r[W-1:0];
        end
    end

    // Control FSM, iteration datapath and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            sdvd_r     <= 1'b0;
            sdvs_r     <= 1'b0;
            dvs_zero_r <= 1'b0;
            dvd_mag_r  <= '0;
            dvs_mag_r  <= '0;
            prem_r     <= '0;
            qmag_r     <= '0;
            cnt_r      <= '0;
            quot       <= '0;
            rem        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ovf        <= 1'b0;
            dbz        <= 1'b0;
        end else if (start) begin
            sdvd_r     <= dvd[2*W-1];
            sdvs_r     <= dvs[W-1];
            dvs_zero_r <= (dvs == '0);
            dvd_mag_r  <= dvd_abs_s;
            dvs_mag_r  <= dvs_abs_s;
            prem_r     <= '0;
            qmag_r     <= '0;
            cnt_r      <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            if (dvs == '0) begin
                state_r <= FIX;
            end else begin
                state_r <= RUN;
            end
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                RUN: begin
                    dvd_mag_r <= {dvd_mag_r[2*W-2:0], 1'b0};
                    if (!diff_s[W+1]) begin
                        prem_r <= diff_s[W:0];
                        qmag_r <= {qmag_r[2*W-2:0], 1'b1};
                    end else begin
                        prem_r <= shift_s;
                        qmag_r <= {qmag_r[2*W-2:0], 1'b0};
                    end
                    cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == LAST_ITER) begin
                        state_r <= FIX;
                    end else begin
                        state_r <= RUN;
                    end
                end
                FIX: begin
                    dbz  <= dvs_zero_r;
                    ovf  <= dvs_zero_r | q_ovf_s;
                    if (dvs_zero_r || q_ovf_s) begin
                        quot <= '0;
                        rem  <= '0;
                    end else begin
                        quot <= quot_s;
                        rem  <= rem_s;
                    end
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_div.sv
// Self-checking bench for booth_div (W=8): directed cases from the test plan plus
// randomized operands checked against a plain-arithmetic reference model.
module tb_booth_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dvd;
    logic [7:0]  dvs;
    logic [7:0]  quot;
    logic [7:0]  rem;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        dbz;

    int vectors;
    int miscompares;
    logic [7:0] prev_q;
    logic [7:0] prev_r;

    booth_div #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .dvd   (dvd),
        .dvs   (dvs),
        .quot  (quot),
        .rem   (rem),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: signed integer division truncating toward zero, remainder follows dividend.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic o, output logic z, output int lat);
        longint sa;
        longint sb;
        longint qi;
        longint ri;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = 8'd0; r = 8'd0; o = 1'b1; z = 1'b1; lat = 1;
        end else begin
            qi = sa / sb;
            ri = sa % sb;
            z = 1'b0;
            lat = 17;
            if (qi > 127 || qi < -128) begin
                q = 8'd0; r = 8'd0; o = 1'b1;
            end else begin
                q = qi[7:0]; r = ri[7:0]; o = 1'b0;
            end
        end
    endtask

    // Called at a negedge: presents operands for the next rising edge, then drops start.
    task automatic issue(input logic [15:0] a, input logic [7:0] b);
        start = 1'b1;
        dvd = a;
        dvs = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_check(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [7:0] eq;
        logic [7:0] er;
        logic eo;
        logic ez;
        int lat;
        int edges;
        model(a, b, eq, er, eo, ez, lat);
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_hold"}, {16'd0, quot, rem}, {16'd0, prev_q, prev_r});
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(negedge clk);
            edges++;
        end
        check({tag, "_lat"}, edges, lat);
        check({tag, "_quot"}, {24'd0, quot}, {24'd0, eq});
        check({tag, "_rem"}, {24'd0, rem}, {24'd0, er});
        check({tag, "_flags"}, {29'd0, ovf, dbz, busy}, {29'd0, eo, ez, 1'b0});
        prev_q = eq;
        prev_r = er;
        @(negedge clk);
        check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    task automatic do_op(input string tag, input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        issue(a, b);
        wait_check(tag, a, b);
    endtask

    initial begin
        logic [15:0] ra;
        logic [7:0]  rb;
        logic        seen;
        vectors = 0;
        miscompares = 0;
        prev_q = 8'd0;
        prev_r = 8'd0;
        rst_n = 1'b0;
        start = 1'b0;
        dvd = 16'd0;
        dvs = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {26'd0, quot[0] | (|quot), |rem, busy, done, ovf, dbz}, 32'd0);
        rst_n = 1'b1;

        do_op("basic", 16'd100, 8'd7);
        do_op("neg_dvd", 16'hFF9C, 8'd7);
        do_op("neg_dvs", 16'd100, 8'hF9);
        do_op("neg_both", 16'hFF9C, 8'hF9);
        do_op("min_quot", 16'd16384, 8'h80);
        do_op("ovf_pos", 16'hC000, 8'h80);
        do_op("ovf_big", 16'd32767, 8'd1);
        do_op("min_dvd", 16'h8000, 8'h80);
        do_op("dbz", 16'd1234, 8'd0);
        do_op("after_dbz", 16'd50, 8'd5);

        // Restart five edges into an operation: only the second one completes.
        @(negedge clk);
        issue(16'd100, 8'd7);
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | done;
        end
        check("restart_nodone", {31'd0, seen}, 32'd0);
        issue(16'd200, 8'd9);
        wait_check("restart", 16'd200, 8'd9);

        // A new start on the FIX edge wins and suppresses the pending done.
        @(negedge clk);
        issue(16'd300, 8'd11);
        repeat (16) @(negedge clk);
        issue(16'hFE0C, 8'd13);
        wait_check("fix_start", 16'hFE0C, 8'd13);

        // Asynchronous reset mid-run.
        @(negedge clk);
        issue(16'd1000, 8'd3);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid", {26'd0, |quot, |rem, busy, done, ovf, dbz}, 32'd0);
        prev_q = 8'd0;
        prev_r = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | done | busy;
        end
        check("rst_quiet", {31'd0, seen}, 32'd0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            ra = 16'($signed(ra) >>> $urandom_range(0, 15));
            rb = 8'($urandom);
            if (i % 13 == 5) begin
                rb = 8'd0;
            end else begin
                rb = rb;
            end
            do_op("rand", ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/booth_div.md
Name: booth_div

Overview:
- Sequential signed restoring divider, the inverse companion of the team's Booth multiplier.
- Divides a 2W-bit two's-complement dividend by a W-bit two's-complement divisor, one quotient bit per clock.
- Produces a W-bit quotient and a W-bit remainder, with overflow and divide-by-zero flags.
- Sits beside the multiplier in the CPU datapath and uses the same start/busy handshake style.

Parameters:
- W, 8: divisor, quotient and remainder width. Dividend width is 2W.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  synchronous request; operands sampled on the same edge
- dvd  input  2W  signed dividend
- dvs  input  W  signed divisor
- quot  output  W  signed quotient, truncated toward zero
- rem  output  W  signed remainder; sign follows dividend
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when results become valid
- ovf  output  1  quotient not representable in W bits, or divide-by-zero
- dbz  output  1  divisor was zero

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; quot, rem, busy, done, ovf, dbz, iteration counter and all internal registers go to 0. Reset mid-operation abandons the operation with no done pulse.
- States: IDLE, RUN, FIX.
- Start edge (any state, including RUN or FIX):
  - Latch sign(dvd), sign(dvs), |dvd| (2W-bit unsigned) and |dvs| (W-bit unsigned).
  - Clear the (W+1)-bit partial remainder, the 2W-bit quotient magnitude and the counter.
  - busy=1, done=0. Go to RUN; if dvs==0, go to FIX directly.
  - Start while busy aborts the current operation and restarts with the new operands.
- RUN (one iteration per edge, 2W edges):
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial-subtract |dvs|. If the result is non-negative, keep it and shift a 1 into the quotient magnitude; otherwise restore and shift a 0.
  - After the 2W-th iteration, go to FIX.
- FIX (one edge), then IDLE:
  - Negate the quotient if sign(dvd)^sign(dvs).
  - Negate the remainder if sign(dvd).
  - ovf=1 if the quotient magnitude exceeds 2^(W-1)-1 for a positive result, or 2^(W-1) for a negative result.
  - On ovf or dbz: quot=0, rem=0. Otherwise drive quot and rem with the signed results.
  - dbz set from the latched divisor-zero condition; ovf=1 whenever dbz=1.
  - busy=0, done=1 for exactly one cycle.
- Latency:
  - Normal case: done and valid results 2W+1 edges after the start edge (17 for W=8); busy high for those cycles.
  - Divide-by-zero: done 1 edge after the start edge.
- Outputs quot, rem, ovf and dbz hold their values until the next FIX edge or reset. start does not clear them.
- Edge cases:
  - start=1 on the same edge as FIX: start wins; no done pulse.
  - Most-negative operands: |dvd|=2^(2W-1) and |dvs|=2^(W-1) must be handled exactly, with no internal overflow.

Test Plan (W=8):
- dvd=100 (0x0064), dvs=7, start pulse -> 17 edges later done=1, quot=14 (0x0E), rem=2, ovf=0, dbz=0, busy low.
- Sign matrix:
  - -100 (0xFF9C)/7 -> quot=0xF2, rem=0xFE.
  - 100/-7 -> quot=0xF2, rem=0x02.
  - -100/-7 -> quot=0x0E, rem=0xFE.
- Boundaries:
  - 16384/-128 -> quot=0x80, rem=0, ovf=0.
  - -16384/-128 -> ovf=1, quot=0, rem=0.
  - 32767/1 -> ovf=1.
- dvd=1234, dvs=0 -> done 1 edge after start, dbz=1, ovf=1, quot=0, rem=0.
- Restart: start 100/7, then start 200/9 five edges later -> a single done 17 edges after the second start, quot=22, rem=2.
- Reset: rst_n low during RUN -> busy, done, quot, rem, ovf and dbz drop to 0 immediately; no done pulse after release until a new start.
